// File: rtl/trng_pkg.sv
// Shared types and default sizing for the TRNG output stage.
// Holds the packer state encoding and the default word/FIFO/warm-up sizes.
package trng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_PACK   = 2'd2
    } state_e;

    localparam int DEF_WORD_W      = 32;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_WARMUP_BITS = 64;

endpackage

// File: rtl/trng_fifo.sv
// Show-ahead word FIFO: a pushed word is visible at o_head on the same edge that writes it.
// Latency 1 edge, push to head; a push into a full FIFO is taken only if a pop happens on that edge.
module trng_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    // Head is forced to zero when empty so the output reads 0 straight out of reset.
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/trng_word_packer.sv
// Drops a warm-up prefix after each RUN entry, packs later bits MSB-first into words, and queues them.
// A word is valid on the edge its last bit is sampled; a word completing into a full FIFO is dropped (sticky overflow).
module trng_word_packer
    import trng_pkg::*;
#(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int WARMUP_BITS = DEF_WARMUP_BITS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             run_en,
    input  logic                             bit_valid,
    input  logic                             bit_in,
    output logic                             out_valid,
    output logic [WORD_W-1:0]                out_data,
    input  logic                             out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  level,
    output logic                             overflow
);

    localparam int BC_W = $clog2(WORD_W);
    localparam int WU_W = (WARMUP_BITS > 1) ? $clog2(WARMUP_BITS) : 1;

    state_e            r_state;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [WU_W-1:0]   r_wu_cnt;
    logic [WORD_W-1:0] r_sr;
    logic              r_ovf;

    logic              w_word_done;
    logic [WORD_W-1:0] w_word;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;

    assign w_word      = {r_sr[WORD_W-2:0], bit_in};
    assign w_word_done = (r_state == ST_PACK) & run_en & bit_valid
                       & (r_bit_cnt == BC_W'(WORD_W - 1));
    assign w_pop       = out_valid & out_ready;
    assign out_valid   = ~w_empty;
    assign overflow    = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_wu_cnt  <= '0;
            r_sr      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run_en) r_state <= (WARMUP_BITS == 0) ? ST_PACK : ST_WARMUP;
                end
                ST_WARMUP: begin
                    if (!run_en) begin
                        r_state  <= ST_IDLE;
                        r_wu_cnt <= '0;
                    end else if (bit_valid) begin
                        if (r_wu_cnt == WU_W'(WARMUP_BITS - 1)) begin
                            r_state  <= ST_PACK;
                            r_wu_cnt <= '0;
                        end else begin
                            r_wu_cnt <= r_wu_cnt + WU_W'(1);
                        end
                    end
                end
                ST_PACK: begin
                    // Leaving RUN throws away the partial word; queued words stay.
                    if (!run_en) begin
                        r_state   <= ST_IDLE;
                        r_bit_cnt <= '0;
                        r_sr      <= '0;
                    end else if (bit_valid) begin
                        r_sr      <= w_word;
                        r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + BC_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ovf <= 1'b0;
        else        r_ovf <= r_ovf | (w_word_done & w_full & ~w_pop);
    end

    trng_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_word_done),
        .i_push_dat (w_word),
        .i_pop      (out_ready),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (level),
        .o_head     (out_data)
    );

endmodule

// File: tb/tb_trng_word_packer.sv
// Bench for trng_word_packer: random and directed bitstreams checked against a queue-based reference model.
module tb_trng_word_packer;

    localparam int WORD_W = 32;
    localparam int DEPTH  = 4;
    localparam int WARMUP = 64;

    logic        clk;
    logic        rst_n;
    logic        run_en, bit_valid, bit_in, out_ready;
    logic        out_valid, overflow;
    logic [31:0] out_data;
    logic [2:0]  level;

    logic        run_en0, bit_valid0, bit_in0, out_ready0;
    logic        out_valid0, overflow0;
    logic [31:0] out_data0;
    logic [2:0]  level0;

    trng_word_packer #(.WORD_W(WORD_W), .FIFO_DEPTH(DEPTH), .WARMUP_BITS(WARMUP)) dut (
        .clk(clk), .rst_n(rst_n), .run_en(run_en), .bit_valid(bit_valid), .bit_in(bit_in),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level), .overflow(overflow)
    );

    trng_word_packer #(.WORD_W(WORD_W), .FIFO_DEPTH(DEPTH), .WARMUP_BITS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .run_en(run_en0), .bit_valid(bit_valid0), .bit_in(bit_in0),
        .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready0),
        .level(level0), .overflow(overflow0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: RUN seen on the previous edge, bits accepted since entering RUN,
    // the partially assembled word, and the queue of buffered words.
    bit          m_active;
    int          m_acc;
    int          m_nbits;
    logic [31:0] m_sr;
    logic [31:0] m_q[$];
    bit          m_ovf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_acc    = 0;
        m_nbits  = 0;
        m_sr     = '0;
        m_q.delete();
        m_ovf    = 1'b0;
    endtask

    task automatic step();
        bit pop;
        @(posedge clk);
        pop = (m_q.size() != 0) && out_ready;
        if (pop) void'(m_q.pop_front());
        if (m_active && run_en && bit_valid) begin
            m_acc++;
            if (m_acc > WARMUP) begin
                m_sr = {m_sr[30:0], bit_in};
                m_nbits++;
                if (m_nbits == WORD_W) begin
                    m_nbits = 0;
                    if (m_q.size() < DEPTH) m_q.push_back(m_sr);
                    else                    m_ovf = 1'b1;
                end
            end
        end
        if (!run_en) begin
            m_acc   = 0;
            m_nbits = 0;
        end
        m_active = run_en;
        #1;
        check_eq("valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
        check_eq("level", {29'd0, level}, m_q.size());
        check_eq("ovf", {31'd0, overflow}, {31'd0, m_ovf});
        if (m_q.size() != 0) check_eq("data", out_data, m_q[0]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic feed_random(input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom);
            step();
        end
    endtask

    task automatic feed_word(input logic [31:0] w, input bit rdy_last);
        for (int i = 31; i >= 0; i--) begin
            bit_valid = 1'b1;
            bit_in    = w[i];
            if (i == 0 && rdy_last) out_ready = 1'b1;
            step();
        end
        if (rdy_last) out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] pat;
        rst_n = 1'b0; run_en = 0; bit_valid = 0; bit_in = 0; out_ready = 0;
        run_en0 = 0; bit_valid0 = 0; bit_in0 = 0; out_ready0 = 0;
        do_reset();

        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_data", out_data, 32'd0);
        check_eq("rst_level", {29'd0, level}, 32'd0);
        check_eq("rst_ovf", {31'd0, overflow}, 32'd0);

        // No warm-up instance: 0xA5A50F0F with bit_valid on every other cycle.
        pat = 32'hA5A50F0F;
        run_en0 = 1'b1;
        step();
        for (int i = 0; i < 64; i++) begin
            bit_valid0 = (i % 2 == 0);
            bit_in0    = pat[31 - i / 2];
            step();
        end
        check_eq("nw_valid", {31'd0, out_valid0}, 32'd1);
        check_eq("nw_data", out_data0, 32'hA5A50F0F);
        bit_valid0 = 1'b0;
        repeat (20) step();
        check_eq("nw_level", {29'd0, level0}, 32'd1);
        run_en0 = 1'b0;

        // All ones: first word after 96 accepted bits.
        do_reset();
        run_en = 1; bit_valid = 1; bit_in = 1;
        repeat (96) step();
        check_eq("ones_early", {31'd0, out_valid}, 32'd0);
        step();
        check_eq("ones_valid", {31'd0, out_valid}, 32'd1);
        check_eq("ones_data", out_data, 32'hFFFFFFFF);
        check_eq("ones_level", {29'd0, level}, 32'd1);

        // Fill to 4, overflow on the 5th, then drain in order.
        do_reset();
        run_en = 1; bit_valid = 0;
        step();
        feed_random(WARMUP);
        for (int k = 1; k <= 4; k++) feed_word(k, 1'b0);
        check_eq("fill_level", {29'd0, level}, 32'd4);
        check_eq("fill_ovf", {31'd0, overflow}, 32'd0);
        feed_word(32'd5, 1'b0);
        check_eq("over_level", {29'd0, level}, 32'd4);
        check_eq("over_ovf", {31'd0, overflow}, 32'd1);
        run_en = 0; bit_valid = 0; out_ready = 1;
        for (int k = 1; k <= 4; k++) begin
            check_eq("drain_data", out_data, k);
            step();
        end
        check_eq("drain_empty", {31'd0, out_valid}, 32'd0);
        out_ready = 0;

        // Full FIFO, 5th word completes on a popping edge: no overflow.
        do_reset();
        run_en = 1; bit_valid = 0;
        step();
        feed_random(WARMUP);
        for (int k = 0; k < 4; k++) feed_word($urandom, 1'b0);
        feed_word($urandom, 1'b1);
        check_eq("pp_ovf", {31'd0, overflow}, 32'd0);
        check_eq("pp_level", {29'd0, level}, 32'd4);

        // RUN drop mid-word: partial bits lost, fresh warm-up, queued words kept.
        run_en = 0; bit_valid = 0; out_ready = 1;
        repeat (2) step();
        out_ready = 0; run_en = 1;
        step();
        feed_random(WARMUP + 10);
        run_en = 0; bit_valid = 0;
        repeat (2) step();
        check_eq("drop_level", {29'd0, level}, 32'd2);
        run_en = 1;
        step();
        feed_random(WARMUP);
        pat = 32'h12345678;
        feed_word(pat, 1'b0);
        check_eq("rerun_level", {29'd0, level}, 32'd3);
        run_en = 0; bit_valid = 0; out_ready = 1;
        repeat (2) step();
        check_eq("rerun_data", out_data, 32'h12345678);
        out_ready = 0;

        // Asynchronous reset mid-word with level 2 and overflow set.
        do_reset();
        run_en = 1; bit_valid = 0;
        step();
        feed_random(WARMUP);
        for (int k = 0; k < 6; k++) feed_word($urandom, 1'b0);
        bit_valid = 0; out_ready = 1;
        repeat (2) step();
        out_ready = 0;
        feed_random(10);
        check_eq("pre_level", {29'd0, level}, 32'd2);
        check_eq("pre_ovf", {31'd0, overflow}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("arst_data", out_data, 32'd0);
        check_eq("arst_level", {29'd0, level}, 32'd0);
        check_eq("arst_ovf", {31'd0, overflow}, 32'd0);
        do_reset();
        bit_valid = 1;
        for (int i = 0; i < 96; i++) begin
            bit_in = 1'($urandom);
            step();
        end
        check_eq("arst_idle_early", {31'd0, out_valid}, 32'd0);
        bit_in = 1'($urandom);
        step();
        check_eq("arst_idle_word", {31'd0, out_valid}, 32'd1);

        // Random traffic with varying consumer pressure.
        do_reset();
        for (int blk = 0; blk < 15; blk++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(0, 100);
            for (int i = 0; i < 200; i++) begin
                run_en    = ($urandom_range(0, 199) != 0);
                bit_valid = ($urandom_range(0, 3) != 0);
                bit_in    = 1'($urandom);
                out_ready = ($urandom_range(0, 99) < rdy_pct);
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trng_word_packer.md
# trng_word_packer

Consumer-side output stage of the TRNG. It accepts the serial random bitstream the core produces while the control FSM is in RUN and discards a warm-up prefix after every entry into RUN. It packs the remaining bits MSB-first into words, buffers them in a small show-ahead FIFO, and presents them on a valid/ready interface to the system side.

## Interface
Parameters:
- WORD_W, 32, output word width in bits (≥ 2)
- FIFO_DEPTH, 4, buffered words (power of 2, ≥ 2)
- WARMUP_BITS, 64, accepted bits discarded after each rising edge of run_en (0 = no warm-up)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- run_en  in  1  RUN indication from the control FSM
- bit_valid  in  1  bit_in carries a fresh random bit this cycle
- bit_in  in  1  serial random bit
- out_valid  out  1  out_data holds a word
- out_data  out  WORD_W  head-of-FIFO word
- out_ready  in  1  consumer accepts the word when out_valid is also high
- level  out  $clog2(FIFO_DEPTH+1)  words currently buffered
- overflow  out  1  sticky: a completed word was dropped

## Operation
- A bit is "accepted" when the edge samples run_en=1 and bit_valid=1 while the state is WARMUP or PACK.
- States:
  - IDLE: no bits accepted.
    - run_en=1 → WARMUP, or → PACK directly if WARMUP_BITS=0.
  - WARMUP: accepted bits are counted and discarded.
    - The WARMUP_BITSth accepted bit → PACK.
    - run_en=0 → IDLE and the counter clears.
  - PACK: accepted bits shift into the shift register, sr <= {sr[WORD_W-2:0], bit_in}, so the first bit lands in the MSB.
    - The WORD_WTH bit completes the word. The word {sr[WORD_W-2:0], bit_in} is pushed and the bit counter wraps to 0 on the same edge.
    - run_en=0 → IDLE. A partial word and its bit count are discarded. FIFO contents are kept.
- Push rule: the push succeeds if level < FIFO_DEPTH, or if a pop happens on the same edge (out_valid & out_ready). Otherwise the word is dropped and overflow is set.
- Pop: out_valid & out_ready on an edge advances the head.
- Push and pop on the same edge leave level unchanged.
- overflow is cleared only by rst_n.
- out_data is don't-care while out_valid=0, but it must hold stable while out_valid=1 and out_ready=0.

## Timing
- Reset values:
  - out_valid=0, out_data=0, level=0, overflow=0
  - state IDLE; all counters and the shift register are 0
  - FIFO pointers are 0
- Reset acts immediately, without waiting for a clock edge.
- Latency: when the last bit of a word is sampled at edge k into an empty FIFO, out_valid=1 is visible from edge k through at least the next edge.
- Throughput: one bit per cycle at most. Gaps in bit_valid only stall packing.
- Minimum RUN length before the first word: WARMUP_BITS + WORD_W accepted bits.
- run_en rising and bit_valid=1 on the same edge: this bit is not accepted, because the state is still IDLE. Acceptance starts the edge after.
- run_en falling: takes effect on the edge where it is sampled low. A bit presented on that edge is ignored.

## Structure
- Shared package trng_pkg:
  - state enum (IDLE, WARMUP, PACK)
  - default WORD_W, FIFO_DEPTH and WARMUP_BITS constants
- Sub-module trng_fifo: a synchronous show-ahead FIFO with push, pop, full, empty and level, sharing the same clk/rst_n.
- The packer FSM, counters and shift register live in trng_word_packer.

## Test plan
- Defaults, reset release, run_en=1, bit_valid=1 continuously, all-ones bitstream → out_valid first rises after the 96th accepted bit; out_data=0xFFFFFFFF; level=1.
- WARMUP_BITS=0, run_en=1, bits 0xA5A50F0F fed MSB-first with bit_valid toggling every other cycle → out_data=0xA5A50F0F after 64 cycles; no extra word produced.
- out_ready=0, push 5 words (values 1..5) → level=4 after word 4 and overflow=1 after word 5; with out_ready=1, reads return 1,2,3,4 in order and then out_valid=0.
- FIFO full, with the 5th word completing on the same edge as a pop → overflow stays 0 and level stays 4.
- run_en drops after 10 bits of a word, then rises again → the 10 bits are lost and a fresh 64-bit warm-up occurs; the next word contains only post-warm-up bits; FIFO contents are unchanged.
- rst_n pulled low mid-word with level=2 and overflow=1 → all outputs go to 0 before the next clk edge; state returns to IDLE.
